// File: rtl/sensor_conditioner_if.sv
// Raw sensor pins in, conditioned detection flags out, between the pin
// front end and the state machine that consumes them.
interface sensor_conditioner_if;
  logic light_raw;
  logic sound_raw;
  logic move_raw;
  logic light_detected;
  logic sound_detected;
  logic movement_detected;
  logic event_pulse;

  modport master (
    output light_raw, sound_raw, move_raw,
    input  light_detected, sound_detected, movement_detected, event_pulse
  );

  modport slave (
    input  light_raw, sound_raw, move_raw,
    output light_detected, sound_detected, movement_detected, event_pulse
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronizes, debounces and pulse-stretches the three sensor pins and flags
// each new detection with a one-cycle event pulse. Channel order: light, sound, move.
module sensor_conditioner #(
  parameter int DEBOUNCE         = 16,
  parameter int HOLD             = 64,
  parameter bit LIGHT_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_conditioner_if.slave  bus
);
  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam int             HW       = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [2:0]     POL      = {2'b00, LIGHT_ACTIVE_LOW};
  localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [HW-1:0]  HOLD_VAL = HW'(HOLD);

  logic [2:0]    raw;
  logic [2:0]    sync_p0, sync_p1, cond_p1;
  logic [2:0]    db_p2;
  logic [CW-1:0] cnt_p2 [3];
  logic [HW-1:0] hold_p3 [2];
  logic [2:0]    det_p3, prev_p4;
  logic          event_p4;

  assign raw = {bus.move_raw, bus.sound_raw, bus.light_raw};

  // Stage p0/p1: two-flop synchronizers; light resets to its inactive pin level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= POL;
      sync_p1 <= POL;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  assign cond_p1 = sync_p1 ^ POL;

  // Stage p2: debounce, value must disagree for DEBOUNCE consecutive samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_p2 <= '0;
      for (int i = 0; i < 3; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cond_p1[i] == db_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == DB_LAST) begin
          db_p2[i]  <= cond_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  // Stage p3: hold counters stretch sound and movement after the debounced fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) hold_p3[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (db_p2[i+1])
          hold_p3[i] <= HOLD_VAL;
        else if (hold_p3[i] != '0)
          hold_p3[i] <= hold_p3[i] - 1'b1;
      end
    end
  end

  assign det_p3[0] = db_p2[0];
  assign det_p3[1] = db_p2[1] | (hold_p3[0] != '0);
  assign det_p3[2] = db_p2[2] | (hold_p3[1] != '0);

  // Stage p4: rise detection against last cycle's outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_p4  <= '0;
      event_p4 <= 1'b0;
    end else begin
      prev_p4  <= det_p3;
      event_p4 <= |(det_p3 & ~prev_p4);
    end
  end

  assign bus.light_detected    = det_p3[0];
  assign bus.sound_detected    = det_p3[1];
  assign bus.movement_detected = det_p3[2];
  assign bus.event_pulse       = event_p4;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE=4, HOLD=8: one instance
// with active-high light, one with active-low light.
module tb_sensor_conditioner;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  sensor_conditioner_if ifa();
  sensor_conditioner_if ifb();

  sensor_conditioner #(.DEBOUNCE(4), .HOLD(8), .LIGHT_ACTIVE_LOW(1'b0)) dut_a (
    .clk (clk),
    .rst (rst_n),
    .bus (ifa.slave)
  );

  sensor_conditioner #(.DEBOUNCE(4), .HOLD(8), .LIGHT_ACTIVE_LOW(1'b1)) dut_b (
    .clk (clk),
    .rst (rst_n),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         l;
    bit         s;
    bit         m;
    int         n;
    logic [3:0] exp;  // {light, sound, move, event}
  } vec_t;

  vec_t tbl [24];

  function automatic logic [3:0] outs_a();
    return {ifa.light_detected, ifa.sound_detected, ifa.movement_detected, ifa.event_pulse};
  endfunction

  function automatic logic [3:0] outs_b();
    return {ifb.light_detected, ifb.sound_detected, ifb.movement_detected, ifb.event_pulse};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int gaps;
    int pulses;
    int bad;

    n_total = 0;
    n_pass  = 0;
    tbl = '{
      '{1'b0, 1'b0, 1'b0,  2, 4'b0000},
      '{1'b1, 1'b0, 1'b0,  5, 4'b0000},
      '{1'b1, 1'b0, 1'b0,  1, 4'b1000},
      '{1'b1, 1'b0, 1'b0,  1, 4'b1001},
      '{1'b1, 1'b0, 1'b0,  1, 4'b1000},
      '{1'b0, 1'b0, 1'b0,  5, 4'b1000},
      '{1'b0, 1'b0, 1'b0,  1, 4'b0000},
      '{1'b0, 1'b0, 1'b0,  4, 4'b0000},
      '{1'b0, 1'b1, 1'b0,  3, 4'b0000},
      '{1'b0, 1'b0, 1'b0,  3, 4'b0000},
      '{1'b0, 1'b0, 1'b0,  6, 4'b0000},
      '{1'b0, 1'b1, 1'b0,  4, 4'b0000},
      '{1'b0, 1'b0, 1'b0,  1, 4'b0000},
      '{1'b0, 1'b0, 1'b0,  1, 4'b0100},
      '{1'b0, 1'b0, 1'b0,  1, 4'b0101},
      '{1'b0, 1'b0, 1'b0, 10, 4'b0100},
      '{1'b0, 1'b0, 1'b0,  1, 4'b0000},
      '{1'b0, 1'b0, 1'b0,  3, 4'b0000},
      '{1'b0, 1'b1, 1'b1,  5, 4'b0000},
      '{1'b0, 1'b1, 1'b1,  1, 4'b0110},
      '{1'b0, 1'b1, 1'b1,  1, 4'b0111},
      '{1'b0, 1'b1, 1'b1,  1, 4'b0110},
      '{1'b0, 1'b0, 1'b0,  5, 4'b0110},
      '{1'b0, 1'b0, 1'b0, 20, 4'b0000}
    };

    rst_n         = 1'b0;
    ifa.light_raw = 1'b0;
    ifa.sound_raw = 1'b0;
    ifa.move_raw  = 1'b0;
    ifb.light_raw = 1'b1;
    ifb.sound_raw = 1'b0;
    ifb.move_raw  = 1'b0;

    edges(3);
    check("reset_a", 32'(outs_a()), 32'h0);
    check("reset_b", 32'(outs_b()), 32'h0);
    rst_n = 1'b1;

    // Light rise/fall, glitch reject, minimal pulse, simultaneous rise
    for (int i = 0; i < 24; i++) begin
      ifa.light_raw = tbl[i].l;
      ifa.sound_raw = tbl[i].s;
      ifa.move_raw  = tbl[i].m;
      edges(tbl[i].n);
      check($sformatf("vec%0d", i), 32'(outs_a()), 32'(tbl[i].exp));
    end

    // Retrigger during hold: output stays high, a single event pulse
    gaps   = 0;
    pulses = 0;
    for (int t = 0; t < 50; t++) begin
      if (t == 0)  ifa.move_raw = 1'b1;
      if (t == 20) ifa.move_raw = 1'b0;
      if (t == 26) ifa.move_raw = 1'b1;
      edges(1);
      if (t + 1 >= 6 && !ifa.movement_detected) gaps++;
      if (ifa.event_pulse) pulses++;
    end
    check("retrig_gaps", 32'(gaps), 32'd0);
    check("retrig_pulses", 32'(pulses), 32'd1);
    ifa.move_raw = 1'b0;
    edges(25);
    check("retrig_release", 32'(outs_a()), 32'h0);

    // Active-low light on the second instance
    check("actlow_idle", 32'(outs_b()), 32'h0);
    ifb.light_raw = 1'b0;
    edges(5);
    check("actlow_e5", 32'(outs_b()), 32'b0000);
    edges(1);
    check("actlow_e6", 32'(outs_b()), 32'b1000);
    edges(1);
    check("actlow_e7", 32'(outs_b()), 32'b1001);

    // Reset three cycles into a sound hold
    ifa.sound_raw = 1'b1;
    edges(10);
    ifa.sound_raw = 1'b0;
    edges(9);
    check("midhold_pre", 32'(outs_a()), 32'b0100);
    rst_n = 1'b0;
    #2;
    check("midhold_rst", 32'(outs_a()), 32'h0);
    edges(2);
    rst_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      edges(1);
      if (ifa.sound_detected || ifa.event_pulse) bad++;
    end
    check("midhold_after", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Front end for the Tamagotchi state machine. It takes the three raw, asynchronous sensor pins (photo, microphone, PIR/tilt), then synchronizes, debounces and conditions them. It produces the clean level flags `light_detected`, `sound_detected` and `movement_detected` that the state machine consumes. Sound and movement are pulse-stretched so that short bursts hold the PLAYING/HUNGRY states for a defined minimum time. A one-cycle `event_pulse` flags any new detection for the display/wake logic.

## Interface
- `DEBOUNCE`, 16: consecutive synchronized cycles an input must differ from its debounced value before that value changes. Legal range ≥ 1.
- `HOLD`, 64: stretch cycles that sound/movement stay asserted after their debounced input falls. Legal range ≥ 0; 0 = no stretch.
- `LIGHT_ACTIVE_LOW`, 0: if 1, `light_raw` = 0 means light present.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `light_raw`  in  1  photo sensor, asynchronous.
- `sound_raw`  in  1  microphone comparator, asynchronous, active-high.
- `move_raw`  in  1  movement sensor, asynchronous, active-high.
- `light_detected`  out  1  debounced light level.
- `sound_detected`  out  1  debounced and stretched sound.
- `movement_detected`  out  1  debounced and stretched movement.
- `event_pulse`  out  1  one-cycle pulse when any detected output rises.

## Operation
- **Synchronizer:** one 2-flop synchronizer per raw input.
  - Sound/movement sync flops reset to 0.
  - Light sync flops reset to `LIGHT_ACTIVE_LOW`, the inactive level.
  - Light polarity inversion is applied after the second flop, giving `light_s`.
- **Debounce (per channel):** a register `db` plus a counter of width $clog2(DEBOUNCE+1).
  - Synchronized value == `db`: counter cleared.
  - Synchronized value != `db` and counter == DEBOUNCE-1: `db` takes the new value and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE cycles never changes `db`.
- **Light output:** `light_detected` = `db_light`. No stretch.
- **Sound/movement stretcher:** a hold counter of width $clog2(HOLD+1) per channel.
  - `db` high: hold loads HOLD.
  - `db` low and hold > 0: hold decrements.
  - Output = `db` | (hold != 0), built from registers only.
  - Retrigger during a hold reasserts `db`, reloads hold, and the output stays high without a gap.
- **Event pulse:** `event_pulse` is registered. It is 1 for exactly one cycle after any of the three detected outputs goes 0→1, compared against registered copies of the previous outputs.
  - Simultaneous rises produce a single pulse.
  - Falls produce no pulse.
- **Reset:** asserting `rst` (low) immediately clears all of the following:
  - every `db`, debounce counter and hold counter;
  - the previous-output copies;
  - all four outputs, which read 0 while `rst` is low.
  - After release, debounce restarts from scratch. Valid mid-hold or mid-debounce.

## Timing
- Raw change stable before edge 0:
  - sync2 updates at edge 2;
  - `db` and the detected output update at edge 2+DEBOUNCE (latency DEBOUNCE+2 cycles);
  - `event_pulse` is high during the cycle after edge 3+DEBOUNCE.
- Fall, light: `light_detected` low at edge 2+DEBOUNCE.
- Fall, sound/movement:
  - `db` falls at edge 2+DEBOUNCE;
  - the output falls at edge 2+DEBOUNCE+HOLD.
- No combinational path from any raw input to any output.
- All three channels are independent, with identical latency.

## Test plan
All scenarios use DEBOUNCE=4, HOLD=8. Edges are counted from a raw change applied just before edge 0.

1. **Reset and light rise:** reset with all raw = 0, release, then `light_raw` = 1 held → `light_detected` = 1 from edge 6; `event_pulse` = 1 only between edges 7 and 8; other outputs stay 0.
2. **Glitch reject and minimal pulse:**
   - `sound_raw` high for 3 cycles → `sound_detected` never rises.
   - `sound_raw` high for 4 cycles → `sound_detected` high from edge 6 through edge 18 (12 cycles), low after edge 18.
3. **Retrigger during hold:** `move_raw` 0→1, then 1→0 at t=20 and 0→1 again at t=26, all held well past DEBOUNCE → `movement_detected` stays continuously high and only one `event_pulse` occurs.
4. **Simultaneous rise:** `sound_raw` and `move_raw` rise together → both detected outputs rise at edge 6; exactly one `event_pulse`.
5. **Active-low light:** LIGHT_ACTIVE_LOW=1 with `light_raw` = 1 through and after reset → `light_detected` stays 0. `light_raw` 1→0 → `light_detected` = 1 at edge 6.
6. **Reset mid-hold:** drive `rst` low 3 cycles into a sound hold → all outputs 0 immediately; after release with `sound_raw` = 0, `sound_detected` stays 0 and no `event_pulse` occurs.
